// File: rtl/deser_pkg.sv
// deser_pkg: shared constants, state type and slot helper for the
// one_to_seven_deser serial-to-parallel distributor.
//   SLOTS     - number of bit slots in an assembled word
//   SLOT_W    - width of the slot index
//   LAST_SLOT - index of the final slot of a word
//   state_e   - COLLECT (accepting bits) / STALL (full word parked, output busy)
package deser_pkg;

  localparam int SLOTS  = 7;
  localparam int SLOT_W = 3;

  localparam logic [SLOT_W-1:0] LAST_SLOT = 3'd6;

  typedef enum logic {
    COLLECT = 1'b0,
    STALL   = 1'b1
  } state_e;

  // Slot counter step: 0..6 then back to 0, so 7 is never produced.
  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
    return (s == LAST_SLOT) ? '0 : s + 3'd1;
  endfunction

endpackage

// File: rtl/one_to_seven_deser_slot_decoder.sv
// slot_decoder: 3-to-7 one-hot write-enable decoder, the structural dual of a
// 7-to-1 bit select. Slot index k enables bit k (ORDER=0) or bit 6-k (ORDER=1).
// Ports:
//   slot_i [SLOT_W-1:0] - slot index being written
//   we_o   [SLOTS-1:0]  - one-hot enable; index 3'b111 gives all zeros
module slot_decoder
  import deser_pkg::*;
#(
  parameter int ORDER = 0
) (
  input  logic [SLOT_W-1:0] slot_i,
  output logic [SLOTS-1:0]  we_o
);

  // Each output bit compares against a constant; no comparator ever matches 7,
  // so the unused code decodes to no enable at all.
  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_we
      localparam logic [SLOT_W-1:0] SEL =
        (ORDER != 0) ? SLOT_W'(SLOTS - 1 - gi) : SLOT_W'(gi);
      assign we_o[gi] = (slot_i == SEL);
    end
  endgenerate

endmodule

// File: rtl/one_to_seven_deser.sv
// one_to_seven_deser: serial-to-parallel distributor. Single bits accepted on
// InValid && Ready are routed by a slot counter into a 7-bit shadow word. A
// completed word is presented on Data with an OutValid/OutAck handshake; while
// the output is still occupied, one further completed word can wait in the
// shadow register (STALL) before input is throttled.
// Ports:
//   Clock    - rising-edge clock
//   Resetn   - asynchronous active-low reset
//   Clear    - synchronous flush, highest priority
//   SerialIn - data bit;  InValid - SerialIn valid this cycle
//   Ready    - a bit is accepted this cycle if InValid is high
//   Slot     - slot index the next accepted bit fills (0..6)
//   Data     - completed word, stable while OutValid is high
//   OutValid - Data holds an unconsumed word
//   OutAck   - consumer takes Data at this edge when OutValid is high
module one_to_seven_deser
  import deser_pkg::*;
#(
  parameter int ORDER = 0
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Clear,
  input  logic              SerialIn,
  input  logic              InValid,
  output logic              Ready,
  output logic [SLOT_W-1:0] Slot,
  output logic [SLOTS-1:0]  Data,
  output logic              OutValid,
  input  logic              OutAck
);

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [SLOTS-1:0]  shadow_q, shadow_d;
  logic [SLOTS-1:0]  data_q, data_d;
  logic              out_valid_q, out_valid_d;
  logic              ready_q, ready_d;

  logic [SLOTS-1:0]  slot_we;
  logic [SLOTS-1:0]  merged_word;
  logic              accept;
  logic              word_done;

  slot_decoder #(
    .ORDER (ORDER)
  ) u_slot_decoder (
    .slot_i (slot_q),
    .we_o   (slot_we)
  );

  // Shadow with the incoming bit dropped into its slot; used both for partial
  // words and as the complete word when the last slot is written.
  assign merged_word = (shadow_q & ~slot_we) | (slot_we & {SLOTS{SerialIn}});
  assign accept      = InValid && ready_q;
  assign word_done   = accept && (slot_q == LAST_SLOT);

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    shadow_d    = shadow_q;
    data_d      = data_q;
    out_valid_d = out_valid_q;

    if (Clear) begin
      state_d     = COLLECT;
      slot_d      = '0;
      shadow_d    = '0;
      data_d      = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (word_done) begin
            if (!out_valid_q || OutAck) begin
              // Output free (or being freed this edge): publish directly.
              data_d      = merged_word;
              out_valid_d = 1'b1;
              slot_d      = '0;
              shadow_d    = '0;
            end else begin
              // Output still owned by the consumer: park the word, hold Slot at 6.
              shadow_d = merged_word;
              state_d  = STALL;
            end
          end else begin
            if (accept) begin
              shadow_d = merged_word;
              slot_d   = next_slot(slot_q);
            end
            if (OutAck && out_valid_q) begin
              out_valid_d = 1'b0;
            end
          end
        end
        STALL: begin
          // OutValid is necessarily high here; the parked word replaces it.
          if (OutAck) begin
            data_d   = shadow_q;
            slot_d   = '0;
            shadow_d = '0;
            state_d  = COLLECT;
          end
        end
        default: begin
          state_d = COLLECT;
        end
      endcase
    end
  end

  assign ready_d = (state_d == COLLECT);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= COLLECT;
      slot_q      <= '0;
      shadow_q    <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      shadow_q    <= shadow_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      ready_q     <= ready_d;
    end
  end

  // Registered ready flag, forced low for as long as reset is held.
  assign Ready    = ready_q && Resetn;
  assign Slot     = slot_q;
  assign Data     = data_q;
  assign OutValid = out_valid_q;

endmodule

// File: tb/tb_one_to_seven_deser.sv
// Self-checking bench for one_to_seven_deser. Two instances (ORDER=0 and
// ORDER=1) share all inputs; a queue-based reference model tracks accepted
// bits and completed words and predicts every output after each clock edge.
module tb_one_to_seven_deser;

  logic       Clock    = 1'b0;
  logic       Resetn   = 1'b0;
  logic       Clear    = 1'b0;
  logic       SerialIn = 1'b0;
  logic       InValid  = 1'b0;
  logic       OutAck   = 1'b0;

  logic       Ready0, Ready1;
  logic [2:0] Slot0, Slot1;
  logic [6:0] Data0, Data1;
  logic       OutValid0, OutValid1;

  int n_tests = 0;
  int n_fail  = 0;

  one_to_seven_deser #(.ORDER(0)) u_dut0 (
    .Clock(Clock), .Resetn(Resetn), .Clear(Clear), .SerialIn(SerialIn),
    .InValid(InValid), .Ready(Ready0), .Slot(Slot0), .Data(Data0),
    .OutValid(OutValid0), .OutAck(OutAck)
  );

  one_to_seven_deser #(.ORDER(1)) u_dut1 (
    .Clock(Clock), .Resetn(Resetn), .Clear(Clear), .SerialIn(SerialIn),
    .InValid(InValid), .Ready(Ready1), .Slot(Slot1), .Data(Data1),
    .OutValid(OutValid1), .OutAck(OutAck)
  );

  always #5 Clock = ~Clock;

  // Reference model: bits of the word being assembled (arrival order), up to
  // two completed words (front one is on Data), and the last Data value shown.
  bit         m_bits[$];
  logic [6:0] m_words[$];
  logic [6:0] m_last;

  function automatic logic [6:0] pack_bits();
    logic [6:0] w = '0;
    for (int i = 0; i < m_bits.size(); i++) w[i] = m_bits[i];
    return w;
  endfunction

  function automatic logic [6:0] rev7(input logic [6:0] w);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = w[6-i];
    return r;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_words.delete();
    m_last = '0;
  endtask

  task automatic model_edge(input logic iv, input logic si, input logic ack, input logic clr);
    logic acc;
    if (clr) begin
      model_reset();
    end else begin
      acc = iv && (m_words.size() < 2);
      if (ack && m_words.size() > 0) m_last = m_words.pop_front();
      if (acc) begin
        m_bits.push_back(si);
        if (m_bits.size() == 7) begin
          m_words.push_back(pack_bits());
          m_bits.delete();
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic       e_ov;
    logic [6:0] e_d;
    logic       e_rdy;
    logic [2:0] e_slot;
    e_ov   = (m_words.size() > 0);
    e_d    = e_ov ? m_words[0] : m_last;
    e_rdy  = (m_words.size() < 2);
    e_slot = (m_words.size() == 2) ? 3'd6 : 3'(m_bits.size());
    chk("outvalid0", {7'b0, OutValid0}, {7'b0, e_ov});
    chk("outvalid1", {7'b0, OutValid1}, {7'b0, e_ov});
    chk("data0", {1'b0, Data0}, {1'b0, e_d});
    chk("data1", {1'b0, Data1}, {1'b0, rev7(e_d)});
    chk("ready0", {7'b0, Ready0}, {7'b0, e_rdy});
    chk("ready1", {7'b0, Ready1}, {7'b0, e_rdy});
    chk("slot0", {5'b0, Slot0}, {5'b0, e_slot});
    chk("slot1", {5'b0, Slot1}, {5'b0, e_slot});
  endtask

  task automatic step(input logic iv, input logic si, input logic ack, input logic clr);
    InValid  = iv;
    SerialIn = si;
    OutAck   = ack;
    Clear    = clr;
    @(posedge Clock);
    model_edge(iv, si, ack, clr);
    #1;
    check_all();
  endtask

  task automatic send_word(input logic [6:0] w, input logic ack);
    for (int i = 0; i < 7; i++) step(1'b1, w[i], ack, 1'b0);
  endtask

  task automatic check_in_reset(input string tag);
    chk({tag, "_ready"}, {7'b0, Ready0}, 8'd0);
    chk({tag, "_ov"}, {7'b0, OutValid0}, 8'd0);
    chk({tag, "_data"}, {1'b0, Data0}, 8'd0);
    chk({tag, "_slot"}, {5'b0, Slot0}, 8'd0);
  endtask

  initial begin
    logic       t1 [7];
    int         ov_cycles;
    logic [6:0] rw;

    t1 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    model_reset();

    // Reset state, then release between clock edges.
    repeat (2) @(posedge Clock);
    #2;
    check_in_reset("rst");
    Resetn = 1'b1;
    #1;
    chk("rst_release_ready", {7'b0, Ready0}, 8'd1);
    check_all();

    // Bits 1,0,0,1,1,0,1 with OutAck held high.
    for (int i = 0; i < 7; i++) step(1'b1, t1[i], 1'b1, 1'b0);
    chk("t1_data0", {1'b0, Data0}, 8'b0101_1001);
    chk("t1_data1", {1'b0, Data1}, 8'b0100_1101);
    chk("t1_ov", {7'b0, OutValid0}, 8'd1);
    chk("t1_slot", {5'b0, Slot0}, 8'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Word A waits on the output, word B completes behind it and stalls.
    send_word(7'h55, 1'b0);
    send_word(7'h2A, 1'b0);
    chk("stall_ready", {7'b0, Ready0}, 8'd0);
    chk("stall_data", {1'b0, Data0}, 8'h55);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("stall_hold", {1'b0, Data0}, 8'h55);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ack_data", {1'b0, Data0}, 8'h2A);
    chk("ack_ov", {7'b0, OutValid0}, 8'd1);
    chk("ack_ready", {7'b0, Ready0}, 8'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // InValid on every other cycle across 14 bits.
    ov_cycles = 0;
    for (int i = 0; i < 28; i++) begin
      step((i % 2) == 0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      if (OutValid0) ov_cycles++;
    end
    chk("toggle_words", 8'(ov_cycles), 8'd2);

    // Reset mid-word, then a clean 7'h7F.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    Resetn = 1'b0;
    #1;
    check_in_reset("midrst");
    model_reset();
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    #1;
    check_all();
    send_word(7'h7F, 1'b0);
    chk("after_rst_data", {1'b0, Data0}, 8'h7F);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Clear coincident with a 7th-bit accept and an OutAck.
    send_word(7'h33, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_ov", {7'b0, OutValid0}, 8'd0);
    chk("clr_data", {1'b0, Data0}, 8'd0);
    chk("clr_slot", {5'b0, Slot0}, 8'd0);
    chk("clr_ready", {7'b0, Ready0}, 8'd1);

    // Randomised traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      rw = 7'($urandom);
      step($urandom_range(0, 3) != 0, rw[0], $urandom_range(0, 2) == 0,
           $urandom_range(0, 60) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
